z88_memif: RTL and testbench
============================

Z88_MEMIF -- requirements
Module: z88_memif

Interface
REQ-001 Parameter NSLOTS, default 4: number of memory slots (1..8).
REQ-002 Parameter AW, default 19: slot address width.
REQ-003 Parameter DW, default 8: data width.
REQ-004 Parameter WAIT_CFG, default all zero, NSLOTS*4 bits: nibble i is wait count W(i) for slot i, range 0..15.
REQ-005 clk  in  1  master clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sel_n  in  NSLOTS  per-slot chip selects from the gate array, active low.
REQ-008 roe_n  in  1  read strobe, active low.
REQ-009 wrb_n  in  1  write strobe, active low.
REQ-010 ma  in  AW  memory address.
REQ-011 cdo  in  DW  CPU write data.
REQ-012 mem_do  in  NSLOTS*DW  slot read data, slot i at bits [i*DW +: DW].
REQ-013 mem_a  out  AW  registered slot address.
REQ-014 mem_di  out  DW  registered slot write data.
REQ-015 mem_ce_n  out  NSLOTS  one-hot-low registered slot enable.
REQ-016 mem_oe_n  out  1  slot output enable, active low.
REQ-017 mem_we_n  out  1  slot write enable, active low.
REQ-018 cdi  out  DW  read data to CPU.
REQ-019 wait_n  out  1  CPU wait request, active low.
REQ-020 err  out  1  sticky select-collision flag.

Function
REQ-021 Access request: exactly one sel_n bit low AND (roe_n or wrb_n low); the selected slot is index s.
REQ-022 Read when roe_n low; write only when wrb_n low and roe_n high; both low counts as a read.
REQ-023 FSM states IDLE, ACC, HOLD.
REQ-024 IDLE: when a request is present, latch s, ma, cdo and the read/write type, load counter with W(s), and go to ACC.
REQ-025 ACC: mem_ce_n[s] low; mem_oe_n low for reads; mem_we_n low for writes; counter decrements by 1 each cycle.
REQ-026 ACC lasts exactly W(s)+1 cycles, then goes to HOLD; on a read, cdi captures mem_do slot s at the edge that leaves ACC.
REQ-027 HOLD: all mem strobes high; cdi holds the captured value; return to IDLE the cycle after sel_n[s], roe_n and wrb_n all read high.
REQ-028 wait_n is low when (IDLE and a request is present) or in ACC; it is high otherwise (combinational from state and inputs).
REQ-029 Abort: if sel_n[s] goes high, or both strobes go high during ACC, go to IDLE next cycle; no cdi capture; strobes deassert.
REQ-030 cdi is 8'hFF (all ones) whenever the state is not HOLD or the access is a write.
REQ-031 New requests are ignored in ACC and HOLD; changes on ma, cdo or the selected slot mid-access have no effect on latched values.
REQ-032 The counter never underflows; W=0 gives a single ACC cycle.

Reset
REQ-033 Reset gives state IDLE, counter 0, mem_ce_n all ones, mem_oe_n=1, mem_we_n=1, mem_a=0, mem_di=0, cdi=all ones, err=0.
REQ-034 Reset asserted mid-access aborts the access within the same edge; no write strobe survives reset.

Configuration
REQ-035 Macro Z88_MEMIF_BUSERR_EN defined: when more than one sel_n bit is low with a strobe active, the request is ignored (stays IDLE, wait_n high, cdi all ones) and err sets and stays set until reset.
REQ-036 Macro Z88_MEMIF_BUSERR_EN undefined: on collision the lowest-index low sel_n wins and is treated as a normal request; err is tied 0.

Verification
REQ-037 Read slot 0, W(0)=0, mem_do slot0=8'h3C -> wait_n low 2 cycles, mem_oe_n low 1 cycle, then cdi=8'h3C in HOLD.
REQ-038 Read slot 2, W(2)=3 -> mem_ce_n=4'b1011 for 4 cycles, wait_n low 5 cycles, then cdi=mem_do slot2.
REQ-039 Write slot 1, W(1)=2, ma=19'h12345, cdo=8'hA5 -> mem_we_n low 3 cycles, mem_a=19'h12345, mem_di=8'hA5, cdi stays 8'hFF.
REQ-040 Abort: read slot 3 with W=5; release sel_n[3] after 2 ACC cycles -> IDLE next cycle, strobes high, cdi=8'hFF.
REQ-041 sel_n=4'b1100 with roe_n low -> with the macro defined: err=1 and no strobes; with the macro undefined: slot 0 is accessed and err=0.
REQ-042 Assert reset during ACC of a write -> next cycle mem_we_n=1, mem_ce_n=4'b1111, state IDLE, err=0.

Source files
------------

// File: rtl/z88_memif.sv
// z88_memif: Z88 slot memory interface with per-slot wait states; Z88_MEMIF_BUSERR_EN rejects select collisions and raises err
module z88_memif #(
  parameter int NSLOTS = 4,
  parameter int AW = 19,
  parameter int DW = 8,
  parameter logic [NSLOTS*4-1:0] WAIT_CFG = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSLOTS-1:0]    sel_n,
  input  logic                 roe_n,
  input  logic                 wrb_n,
  input  logic [AW-1:0]        ma,
  input  logic [DW-1:0]        cdo,
  input  logic [NSLOTS*DW-1:0] mem_do,
  output logic [AW-1:0]        mem_a,
  output logic [DW-1:0]        mem_di,
  output logic [NSLOTS-1:0]    mem_ce_n,
  output logic                 mem_oe_n,
  output logic                 mem_we_n,
  output logic [DW-1:0]        cdi,
  output logic                 wait_n,
  output logic                 err
);
  localparam int SW = NSLOTS > 1 ? $clog2(NSLOTS) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt, nlow;
  logic [SW-1:0] s_d, s_q;
  logic wr_q, stb, req, abort;
  logic [DW-1:0] cdi_q;
  assign stb = !roe_n || !wrb_n;
`ifdef Z88_MEMIF_BUSERR_EN
  assign req = stb && nlow == 4'd1;
`else
  assign req = stb && nlow != 4'd0;
`endif
  assign abort = sel_n[s_q] || (roe_n && wrb_n);
  assign wait_n = !((state == IDLE && req) || state == ACC);
  assign cdi = (state == HOLD && !wr_q) ? cdi_q : '1;
  // lowest-index active select wins; count active selects for collision detection
  always_comb begin
    s_d = '0;
    nlow = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      s_d = sel_n[i] ? s_d : SW'(i);
      nlow = nlow + {3'b000, !sel_n[i]};
    end
  end
  // access sequencer: latch request, strobe for W+1 cycles, hold read data until the CPU lets go
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      s_q <= '0;
      wr_q <= 1'b0;
      mem_a <= '0;
      mem_di <= '0;
      mem_ce_n <= '1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      cdi_q <= '1;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= ACC;
          s_q <= s_d;
          wr_q <= roe_n;
          mem_a <= ma;
          mem_di <= cdo;
          cnt <= WAIT_CFG[{s_d, 2'b00} +: 4];
          mem_ce_n <= ~(NSLOTS'(1) << s_d);
          mem_oe_n <= roe_n;
          mem_we_n <= !roe_n || wrb_n;
        end
        ACC: if (abort || cnt == 4'd0) begin
          state <= abort ? IDLE : HOLD;
          mem_ce_n <= '1;
          mem_oe_n <= 1'b1;
          mem_we_n <= 1'b1;
          cdi_q <= (!abort && !wr_q) ? mem_do[s_q*DW +: DW] : cdi_q;
        end else cnt <= cnt - 4'd1;
        HOLD: state <= (sel_n[s_q] && roe_n && wrb_n) ? IDLE : HOLD;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef Z88_MEMIF_BUSERR_EN
  // sticky collision flag, cleared only by reset
  always_ff @(posedge clk) err <= reset ? 1'b0 : err | (stb && nlow > 4'd1);
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_z88_memif.sv
// tb_z88_memif: directed bench for z88_memif with a per-cycle expectation model
module tb_z88_memif;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [3:0] sel_n = 4'hF;
  logic roe_n = 1'b1, wrb_n = 1'b1;
  logic [18:0] ma = '0;
  logic [7:0] cdo = '0;
  logic [31:0] mem_do;
  logic [18:0] mem_a;
  logic [7:0] mem_di, cdi;
  logic [3:0] mem_ce_n;
  logic mem_oe_n, mem_we_n, wait_n, err;
  int tests = 0, fails = 0;
  int wcfg[4] = '{0, 2, 3, 5};
  logic [7:0] dat[4] = '{8'h3C, 8'h99, 8'h5A, 8'h77};
  assign mem_do = {dat[3], dat[2], dat[1], dat[0]};
  logic chk = 1'b0;
  logic [3:0] e_ce;
  logic e_oe, e_we, e_wait, e_err = 1'b0;
  logic [7:0] e_cdi, e_di, last_di = '0, hold_cdi;
  logic [18:0] e_a, last_a = '0;
  int n_wlow = 0, n_oelow = 0, n_welow = 0, n_ce1011 = 0;
  int a0, b0, c0, d0;

  z88_memif #(.NSLOTS(4), .AW(19), .DW(8), .WAIT_CFG(16'h5320)) dut (
    .clk(clk), .reset(reset), .sel_n(sel_n), .roe_n(roe_n), .wrb_n(wrb_n),
    .ma(ma), .cdo(cdo), .mem_do(mem_do), .mem_a(mem_a), .mem_di(mem_di),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .cdi(cdi), .wait_n(wait_n), .err(err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!wait_n) n_wlow++;
    if (!mem_oe_n) n_oelow++;
    if (!mem_we_n) n_welow++;
    if (mem_ce_n == 4'b1011) n_ce1011++;
    if (chk) begin
      check("ce_n", {28'd0, mem_ce_n}, {28'd0, e_ce});
      check("oe_n", {31'd0, mem_oe_n}, {31'd0, e_oe});
      check("we_n", {31'd0, mem_we_n}, {31'd0, e_we});
      check("wait_n", {31'd0, wait_n}, {31'd0, e_wait});
      check("cdi", {24'd0, cdi}, {24'd0, e_cdi});
      check("mem_a", {13'd0, mem_a}, {13'd0, e_a});
      check("mem_di", {24'd0, mem_di}, {24'd0, e_di});
      check("err", {31'd0, err}, {31'd0, e_err});
    end
  end

  task automatic set_exp(input logic [3:0] ce, input logic oe, input logic we, input logic wt,
                         input logic [7:0] c, input logic [18:0] a, input logic [7:0] d);
    e_ce = ce; e_oe = oe; e_we = we; e_wait = wt; e_cdi = c; e_a = a; e_di = d; chk = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one access: request cycle, W+1 strobe cycles (or early release), then hold and release
  task automatic access(input int s, input logic [3:0] sv, input bit wr, input logic [18:0] addr,
                        input logic [7:0] data, input int abort_at);
    int w;
    logic [3:0] ce;
    bit ab;
    w = wcfg[s];
    ce = ~(4'b0001 << s);
    ab = 1'b0;
    sel_n = sv; roe_n = wr; wrb_n = !wr; ma = addr; cdo = data;
    set_exp(4'hF, 1'b1, 1'b1, 1'b0, 8'hFF, last_a, last_di);
    step;
    last_a = addr; last_di = data;
    ma = ~addr; cdo = ~data;
    for (int k = 1; k <= w + 1 && !ab; k++) begin
      ab = (k == abort_at + 1);
      if (ab) sel_n = 4'hF;
      set_exp(ce, wr, !wr, 1'b0, 8'hFF, addr, data);
      step;
    end
    if (ab) begin
      roe_n = 1'b1; wrb_n = 1'b1;
      set_exp(4'hF, 1'b1, 1'b1, 1'b1, 8'hFF, addr, data);
      step;
    end else begin
      for (int k = 0; k < 2; k++) begin
        set_exp(4'hF, 1'b1, 1'b1, 1'b1, wr ? 8'hFF : dat[s], addr, data);
        hold_cdi = cdi;
        step;
      end
      sel_n = 4'hF; roe_n = 1'b1; wrb_n = 1'b1;
      set_exp(4'hF, 1'b1, 1'b1, 1'b1, wr ? 8'hFF : dat[s], addr, data);
      step;
      set_exp(4'hF, 1'b1, 1'b1, 1'b1, 8'hFF, addr, data);
      step;
    end
  endtask

  initial begin
    repeat (3) step;
    reset = 1'b0;
    set_exp(4'hF, 1'b1, 1'b1, 1'b1, 8'hFF, 19'd0, 8'd0);
    step;
    check("rst_ce", {28'd0, mem_ce_n}, 32'hF);
    check("rst_cdi", {24'd0, cdi}, 32'hFF);

    a0 = n_wlow; b0 = n_oelow;
    access(0, 4'b1110, 1'b0, 19'h00011, 8'h00, -1);
    check("r037_wait", n_wlow - a0, 2);
    check("r037_oe", n_oelow - b0, 1);
    check("r037_cdi", {24'd0, hold_cdi}, 32'h3C);

    a0 = n_wlow; d0 = n_ce1011;
    access(2, 4'b1011, 1'b0, 19'h7FFFF, 8'h11, -1);
    check("r038_ce", n_ce1011 - d0, 4);
    check("r038_wait", n_wlow - a0, 5);
    check("r038_cdi", {24'd0, hold_cdi}, 32'h5A);

    c0 = n_welow;
    access(1, 4'b1101, 1'b1, 19'h12345, 8'hA5, -1);
    check("r039_we", n_welow - c0, 3);
    check("r039_cdi", {24'd0, hold_cdi}, 32'hFF);
    check("r039_a", {13'd0, mem_a}, 32'h12345);
    check("r039_di", {24'd0, mem_di}, 32'hA5);

    a0 = n_wlow; b0 = n_oelow;
    access(3, 4'b0111, 1'b0, 19'h00333, 8'h00, 2);
    check("r040_oe", n_oelow - b0, 3);
    check("r040_wait", n_wlow - a0, 4);
    check("r040_cdi", {24'd0, cdi}, 32'hFF);

`ifdef Z88_MEMIF_BUSERR_EN
    sel_n = 4'b1100; roe_n = 1'b0;
    set_exp(4'hF, 1'b1, 1'b1, 1'b1, 8'hFF, last_a, last_di);
    step;
    e_err = 1'b1;
    step;
    sel_n = 4'hF; roe_n = 1'b1;
    step;
    check("r041_err", {31'd0, err}, 32'd1);
    access(0, 4'b1110, 1'b0, 19'h00041, 8'h00, -1);
    check("r041_cdi", {24'd0, hold_cdi}, 32'h3C);
`else
    access(0, 4'b1100, 1'b0, 19'h00041, 8'h00, -1);
    check("r041_err", {31'd0, err}, 32'd0);
    check("r041_cdi", {24'd0, hold_cdi}, 32'h3C);
`endif

    sel_n = 4'b1101; roe_n = 1'b1; wrb_n = 1'b0; ma = 19'h00042; cdo = 8'h5A;
    set_exp(4'hF, 1'b1, 1'b1, 1'b0, 8'hFF, last_a, last_di);
    step;
    set_exp(4'b1101, 1'b1, 1'b0, 1'b0, 8'hFF, 19'h00042, 8'h5A);
    step;
    reset = 1'b1;
    step;
    reset = 1'b0; sel_n = 4'hF; wrb_n = 1'b1;
    e_err = 1'b0; last_a = '0; last_di = '0;
    set_exp(4'hF, 1'b1, 1'b1, 1'b1, 8'hFF, 19'd0, 8'd0);
    check("r042_we", {31'd0, mem_we_n}, 32'd1);
    check("r042_ce", {28'd0, mem_ce_n}, 32'hF);
    check("r042_err", {31'd0, err}, 32'd0);
    step;

    access(2, 4'b1011, 1'b0, 19'h00100, 8'h00, -1);
    check("post_rst_cdi", {24'd0, hold_cdi}, 32'h5A);

    chk = 1'b0;
    step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
